// File: rtl/instr_exec_reader.sv
// Instruction register read-side executor: walks a slot range, decodes each word,
// and presents the signed 64-bit result on a valid/ready port.
module instr_exec_reader #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32,
  parameter int RES_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     read_pointer,
  input  logic [3+2*OP_W-1:0]   instruction_word,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RES_W-1:0]      res_data,
  output logic [2:0]            res_opcode,
  output logic [ADDR_W-1:0]     res_addr,
  output logic                  res_div0
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } opcode_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1 << ADDR_W);

  state_t                   state;
  opcode_t                  opc;
  logic signed [OP_W-1:0]   op_a;
  logic signed [OP_W-1:0]   op_b;
  logic [ADDR_W:0]          rem;
  logic [ADDR_W:0]          sat_count;

  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  div_b;
  logic signed [RES_W-1:0]  result;
  logic                     div0;

  assign sat_count = (count > MAX_CNT) ? MAX_CNT : count;

  // Operands are widened before any arithmetic so MULT is exact and
  // the most-negative / -1 quotient is representable.
  always_comb begin
    a_ext  = {{(RES_W-OP_W){op_a[OP_W-1]}}, op_a};
    b_ext  = {{(RES_W-OP_W){op_b[OP_W-1]}}, op_b};
    div_b  = (op_b == '0) ? RES_W'(1) : b_ext;
    div0   = 1'b0;
    result = '0;
    case (opc)
      OP_ZERO:  result = '0;
      OP_PASSA: result = a_ext;
      OP_PASSB: result = b_ext;
      OP_ADD:   result = a_ext + b_ext;
      OP_SUB:   result = a_ext - b_ext;
      OP_MULT:  result = a_ext * b_ext;
      OP_DIV: begin
        if (op_b == '0) div0 = 1'b1;
        else            result = a_ext / div_b;
      end
      OP_MOD: begin
        if (op_b == '0) div0 = 1'b1;
        else            result = a_ext % div_b;
      end
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      opc          <= OP_ZERO;
      op_a         <= '0;
      op_b         <= '0;
      rem          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_pointer <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_opcode   <= '0;
      res_addr     <= '0;
      res_div0     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (sat_count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              read_pointer <= start_addr;
              rem          <= sat_count;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          opc   <= opcode_t'(instruction_word[3+2*OP_W-1 -: 3]);
          op_a  <= instruction_word[2*OP_W-1 -: OP_W];
          op_b  <= instruction_word[OP_W-1:0];
          state <= EXEC;
        end
        EXEC: begin
          res_data   <= result;
          res_opcode <= opc;
          res_addr   <= read_pointer;
          res_div0   <= div0;
          res_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            read_pointer <= read_pointer + 1'b1;
            rem          <= rem - 1'b1;
            if (rem == (ADDR_W+1)'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_reader.sv
// Bench for instr_exec_reader: slot-level result model with a per-cycle compare
// process, plus directed checks of timing, backpressure, wrap, edge arithmetic and reset.
module tb_instr_exec_reader;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 32;
  localparam int RES_W  = 64;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                start = 1'b0;
  logic                res_ready = 1'b0;
  logic [ADDR_W-1:0]   start_addr = '0;
  logic [ADDR_W:0]     count = '0;
  logic                busy, done, res_valid, res_div0;
  logic [ADDR_W-1:0]   read_pointer, res_addr;
  logic [3+2*OP_W-1:0] instruction_word;
  logic [RES_W-1:0]    res_data;
  logic [2:0]          res_opcode;

  logic [66:0] mem [32];
  assign instruction_word = mem[read_pointer];

  instr_exec_reader #(.ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .busy(busy), .done(done), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_opcode(res_opcode),
    .res_addr(res_addr), .res_div0(res_div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [2:0]  opc;
    logic [63:0] data;
    logic        div0;
  } exp_t;

  exp_t exp_q[$];
  int   valid_starts[$];
  int   passed = 0;
  int   total = 0;
  int   ncyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   launch_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, ncyc);
  endtask

  // What a slot must produce, straight from the opcode table in 64-bit integers.
  function automatic exp_t model_slot(int slot);
    exp_t e;
    logic [66:0] w;
    longint sa, sb, r;
    w  = mem[slot];
    sa = longint'($signed(w[63:32]));
    sb = longint'($signed(w[31:0]));
    r  = 0;
    e.div0 = 1'b0;
    case (w[66:64])
      3'd0: r = 0;
      3'd1: r = sa;
      3'd2: r = sb;
      3'd3: r = sa + sb;
      3'd4: r = sa - sb;
      3'd5: r = sa * sb;
      3'd6: if (sb == 0) e.div0 = 1'b1; else r = sa / sb;
      default: if (sb == 0) e.div0 = 1'b1; else r = sa % sb;
    endcase
    e.addr = 5'(slot);
    e.opc  = w[66:64];
    e.data = r;
    return e;
  endfunction

  // Compare process: mid-low phase, after inputs (driven at negedge) settle.
  always @(negedge clk) begin
    #1;
    ncyc++;
    if (!reset_n) begin
      exp_q.delete();
      check("reset_ctrl", 64'({busy, done, res_valid, res_div0, read_pointer, res_addr, res_opcode}), 64'd0);
      check("reset_data", res_data, 64'd0);
    end else begin
      if (res_valid) begin
        check("busy_while_valid", 64'(busy), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(res_valid), 64'd0);
        end else begin
          check("res_addr", 64'(res_addr), 64'(exp_q[0].addr));
          check("res_opcode", 64'(res_opcode), 64'(exp_q[0].opc));
          check("res_data", res_data, exp_q[0].data);
          check("res_div0", 64'(res_div0), 64'(exp_q[0].div0));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (res_valid && !prev_valid) valid_starts.push_back(ncyc);
      if (done) begin
        done_cnt++;
        last_done_cyc = ncyc;
      end
    end
    prev_valid = res_valid;
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(int slot, logic [2:0] opc, int a, int b);
    mem[slot] = {opc, a, b};
  endtask

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic launch(int addr, int cnt);
    int n;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++) exp_q.push_back(model_slot((addr + i) % 32));
    start      = 1'b1;
    start_addr = 5'(addr);
    count      = 6'(cnt);
    #2 launch_cyc = ncyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      #2;
      n++;
    end
    check("valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic wait_done(int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      #2;
      n++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0, vb;
    for (int i = 0; i < 32; i++) mem[i] = {3'(i % 8), 32'(i * 3 - 50), 32'(i - 4)};

    #2 reset_n = 1'b0;
    tick(2);
    #2 check("idle_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // count==0: done the cycle after the accepting edge, no result.
    d0 = done_cnt;
    launch(0, 0);
    #2;
    check("cnt0_done", 64'(done), 64'd1);
    check("cnt0_valid", 64'(res_valid), 64'd0);
    tick();
    #2;
    check("cnt0_done_fall", 64'(done), 64'd0);
    check("cnt0_busy_fall", 64'(busy), 64'd0);
    check("cnt0_one_pulse", 64'(done_cnt - d0), 64'd1);

    // Basic block with ready tied high: latency and 3-cycle throughput.
    tick();
    load(0, 3'd3, 5, 7);
    load(1, 3'd4, 3, 10);
    load(2, 3'd5, -4, 6);
    load(3, 3'd2, 0, -9);
    res_ready = 1'b1;
    d0 = done_cnt;
    vb = valid_starts.size();
    launch(0, 4);
    wait_done(d0);
    check("blk_nres", 64'(valid_starts.size() - vb), 64'd4);
    if (valid_starts.size() - vb == 4) begin
      for (int i = 0; i < 4; i++)
        check("blk_valid_cycle", 64'(valid_starts[vb + i]), 64'(launch_cyc + 3 + 3 * i));
    end
    check("blk_done_cycle", 64'(last_done_cyc), 64'(launch_cyc + 13));
    check("blk_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: result and pointer held while not ready.
    tick();
    load(5, 3'd3, 100, -1);
    load(6, 3'd5, 3, 3);
    res_ready = 1'b0;
    d0 = done_cnt;
    launch(5, 2);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_data", res_data, 64'd99);
      check("bp_addr", 64'(res_addr), 64'd5);
      check("bp_rptr", 64'(read_pointer), 64'd5);
    end
    tick();
    res_ready = 1'b1;
    tick();
    #2 check("bp_accepted", 64'(res_valid), 64'd0);
    wait_done(d0);

    // Wrap 30,31,0,1.
    tick();
    load(30, 3'd1, -5, 3);
    load(31, 3'd0, 8, 8);
    load(0, 3'd7, 17, 5);
    load(1, 3'd4, -2, 2147483647);
    d0 = done_cnt;
    launch(30, 4);
    wait_done(d0);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    // Edge arithmetic, one result at a time with literal expectations.
    tick();
    load(10, 3'd6, -7, 2);
    load(11, 3'd7, -7, 2);
    load(12, 3'd6, 9, 0);
    load(13, 3'd6, 32'h8000_0000, -1);
    load(14, 3'd5, 32'h8000_0000, 32'h8000_0000);
    load(15, 3'd7, 7, 0);
    res_ready = 1'b0;
    d0 = done_cnt;
    launch(10, 6);
    begin
      logic [63:0] lit [6];
      logic        dz  [6];
      lit = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
              64'h0000_0000_8000_0000, 64'h4000_0000_0000_0000, 64'd0};
      dz  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        wait_valid();
        check("edge_data", res_data, lit[i]);
        check("edge_div0", 64'(res_div0), 64'(dz[i]));
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
      end
    end
    wait_done(d0);

    // Reset during OUT: everything clears, no done pulse.
    tick();
    d0 = done_cnt;
    launch(0, 4);
    wait_valid();
    tick();
    reset_n = 1'b0;
    #2;
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick(3);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    reset_n = 1'b1;
    tick();

    // Re-start, with a stray start while busy that must be ignored.
    res_ready = 1'b1;
    d0 = done_cnt;
    launch(2, 3);
    tick();
    start = 1'b1;
    start_addr = 5'd20;
    count = 6'd5;
    tick();
    start = 1'b0;
    wait_done(d0);
    tick(10);
    check("restart_one_done", 64'(done_cnt - d0), 64'd1);
    check("restart_drained", 64'(exp_q.size()), 64'd0);

    // Count above 32 saturates to a full 32-slot sweep.
    d0 = done_cnt;
    vb = valid_starts.size();
    launch(7, 40);
    wait_done(d0);
    tick(4);
    check("sat_nres", 64'(valid_starts.size() - vb), 64'd32);
    check("sat_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
